rdata_router: RTL and testbench

- Per-slave read-data return router, successor to the two-master data seeker.
- Supports N masters.
- Masters may each have reads outstanding at this slave simultaneously; an in-order tag FIFO records which master each acknowledged read belongs to.
- Each returning rdata beat is steered to the master at the FIFO head, latched in that master's output register, and flagged with a one-cycle data_read pulse.
- Sits between the slave's rdata bus and the master-side read ports; one instance per slave.

---
 rtl/rdata_router.sv | 129 ++++++++++++
 tb/tb_rdata_router.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rdata_router.sv
// rdata_router
//   Per-slave read-data return router. Every accepted read request pushes
//   the requesting master's index into an in-order tag FIFO. Every returning
//   rdata beat pops the head tag, and the beat is latched into that master's
//   output register with a one-cycle data_read pulse on the next edge.
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   ack_valid    slave accepted a request this cycle
//   ack_cmd      command of the accepted request (0 read, 1 write)
//   ack_master   index of the master whose request was accepted
//   rdata_valid  rdata_in carries a read beat this cycle
//   rdata_in     read data from the slave
//   rdata        per-master latched read data, master i at [i*DW +: DW]
//   data_read    one-cycle pulse per master: its rdata was just updated
//   pending      outstanding reads (FIFO occupancy)
//   full         pending == DEPTH
//   empty        pending == 0
//   err_ovf      sticky: a read ack was dropped because the FIFO was full
//   err_unexp    sticky: rdata_valid arrived while the FIFO was empty
module rdata_router #(
  parameter int N_MASTERS = 2,
  parameter int DW        = 32,
  parameter int DEPTH     = 4,
  localparam int MW       = $clog2(N_MASTERS),
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ack_valid,
  input  logic                    ack_cmd,
  input  logic [MW-1:0]           ack_master,
  input  logic                    rdata_valid,
  input  logic [DW-1:0]           rdata_in,
  output logic [N_MASTERS*DW-1:0] rdata,
  output logic [N_MASTERS-1:0]    data_read,
  output logic [CW-1:0]           pending,
  output logic                    full,
  output logic                    empty,
  output logic                    err_ovf,
  output logic                    err_unexp
);

  localparam int PW = $clog2(DEPTH);

  logic [MW-1:0]           tag_mem [DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;

  logic                    rd_ack_p0;
  logic                    push_p0;
  logic                    pop_p0;
  logic [MW-1:0]           head_p0;

  logic [N_MASTERS*DW-1:0] rdata_p1;
  logic [N_MASTERS-1:0]    vld_p1;
  logic                    err_ovf_q;
  logic                    err_unexp_q;

  // ---- stage p0: FIFO control decisions from the current inputs ----
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign rd_ack_p0 = ack_valid & ~ack_cmd;
  // Pop decisions see pre-push state: there is no empty-FIFO bypass.
  assign pop_p0    = rdata_valid & ~empty;
  // A simultaneous pop frees a slot, so a read ack is accepted even when full.
  assign push_p0   = rd_ack_p0 & (~full | pop_p0);
  assign head_p0   = tag_mem[rd_ptr];

  // Tag storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push_p0) begin
      tag_mem[wr_ptr] <= ack_master;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      if (push_p0) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_p0) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push_p0) - CW'(pop_p0);
      if (rd_ack_p0 && !push_p0) begin
        err_ovf_q <= 1'b1;
      end
      if (rdata_valid && empty) begin
        err_unexp_q <= 1'b1;
      end
    end
  end

  // ---- stage p1: steer the popped beat into the head master's register ----
  // A head tag outside 0..N_MASTERS-1 matches no port, so its beat is consumed
  // without touching any master.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_p1 <= '0;
      vld_p1   <= '0;
    end else begin
      vld_p1 <= '0;
      if (pop_p0) begin
        for (int i = 0; i < N_MASTERS; i++) begin
          if (head_p0 == MW'(i)) begin
            rdata_p1[i*DW +: DW] <= rdata_in;
            vld_p1[i]            <= 1'b1;
          end
        end
      end
    end
  end

  assign rdata     = rdata_p1;
  assign data_read = vld_p1;
  assign pending   = count;
  assign err_ovf   = err_ovf_q;
  assign err_unexp = err_unexp_q;

endmodule

// File: tb/tb_rdata_router.sv
module tb_rdata_router;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int DP = 4;
  localparam int MW = 2;
  localparam int CW = 3;

  logic              clk;
  logic              rst_n;
  logic              ack_valid;
  logic              ack_cmd;
  logic [MW-1:0]     ack_master;
  logic              rdata_valid;
  logic [DW-1:0]     rdata_in;
  logic [NM*DW-1:0]  rdata;
  logic [NM-1:0]     data_read;
  logic [CW-1:0]     pending;
  logic              full;
  logic              empty;
  logic              err_ovf;
  logic              err_unexp;

  int n_checks = 0;
  int n_errors = 0;

  rdata_router #(.N_MASTERS(NM), .DW(DW), .DEPTH(DP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ack_valid   (ack_valid),
    .ack_cmd     (ack_cmd),
    .ack_master  (ack_master),
    .rdata_valid (rdata_valid),
    .rdata_in    (rdata_in),
    .rdata       (rdata),
    .data_read   (data_read),
    .pending     (pending),
    .full        (full),
    .empty       (empty),
    .err_ovf     (err_ovf),
    .err_unexp   (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          av;
    logic          ac;
    logic [MW-1:0] am;
    logic          rv;
    logic [DW-1:0] rd;
    logic [NM-1:0] dr;
    logic [CW-1:0] pend;
    logic          ovf;
    logic          unexp;
    logic [NM*DW-1:0] rdat;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rn, input logic av, input logic ac,
                              input logic [MW-1:0] am, input logic rv,
                              input logic [DW-1:0] rd, input logic [NM-1:0] dr,
                              input logic [CW-1:0] pend, input logic ovf,
                              input logic unexp, input logic [DW-1:0] r3,
                              input logic [DW-1:0] r2, input logic [DW-1:0] r1,
                              input logic [DW-1:0] r0);
    vec_t v;
    v.rst_n = rn; v.av = av; v.ac = ac; v.am = am; v.rv = rv; v.rd = rd;
    v.dr = dr; v.pend = pend; v.ovf = ovf; v.unexp = unexp;
    v.rdat = {r3, r2, r1, r0};
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [NM*DW-1:0] act, input logic [NM*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic av, input logic ac,
                       input logic [MW-1:0] am, input logic rv,
                       input logic [DW-1:0] rd);
    @(negedge clk);
    rst_n = rn; ack_valid = av; ack_cmd = ac; ack_master = am;
    rdata_valid = rv; rdata_in = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    chk("data_read", idx, NM*DW'(data_read), NM*DW'(v.dr));
    chk("pending",   idx, NM*DW'(pending),   NM*DW'(v.pend));
    chk("full",      idx, NM*DW'(full),      NM*DW'(v.pend == CW'(DP)));
    chk("empty",     idx, NM*DW'(empty),     NM*DW'(v.pend == '0));
    chk("err_ovf",   idx, NM*DW'(err_ovf),   NM*DW'(v.ovf));
    chk("err_unexp", idx, NM*DW'(err_unexp), NM*DW'(v.unexp));
    chk("rdata",     idx, rdata,             v.rdat);
  endtask

  initial begin
    int prev;
    rst_n = 1'b0; ack_valid = 1'b0; ack_cmd = 1'b0; ack_master = '0;
    rdata_valid = 1'b0; rdata_in = '0;

    //  rn av ac am rv rd          dr       pend ovf unx  r3  r2  r1  r0
    // reset, idle, unexpected beat
    add(0, 0, 0, 0, 0, 0,          4'b0000, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,          4'b0000, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,          4'b0000, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 32'hDEAD,   4'b0000, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,          4'b0000, 0, 0, 0, 0, 0, 0, 0);
    // single read for master 1
    add(1, 1, 0, 1, 0, 0,          4'b0000, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 32'hF,      4'b0010, 0, 0, 0, 0, 0, 32'hF, 0);
    add(1, 0, 0, 0, 0, 0,          4'b0000, 0, 0, 0, 0, 0, 32'hF, 0);
    // interleaved acks 2,0,2,3 then beats A,B,C,D
    add(1, 1, 0, 2, 0, 0,          4'b0000, 1, 0, 0, 0, 0, 32'hF, 0);
    add(1, 1, 0, 0, 0, 0,          4'b0000, 2, 0, 0, 0, 0, 32'hF, 0);
    add(1, 1, 0, 2, 0, 0,          4'b0000, 3, 0, 0, 0, 0, 32'hF, 0);
    add(1, 1, 0, 3, 0, 0,          4'b0000, 4, 0, 0, 0, 0, 32'hF, 0);
    add(1, 0, 0, 0, 1, 32'hA,      4'b0100, 3, 0, 0, 0, 32'hA, 32'hF, 0);
    add(1, 0, 0, 0, 1, 32'hB,      4'b0001, 2, 0, 0, 0, 32'hA, 32'hF, 32'hB);
    add(1, 0, 0, 0, 1, 32'hC,      4'b0100, 1, 0, 0, 0, 32'hC, 32'hF, 32'hB);
    add(1, 0, 0, 0, 1, 32'hD,      4'b1000, 0, 0, 0, 32'hD, 32'hC, 32'hF, 32'hB);
    // fill, overflow, push+pop while full
    add(1, 1, 0, 0, 0, 0,          4'b0000, 1, 0, 0, 32'hD, 32'hC, 32'hF, 32'hB);
    add(1, 1, 0, 1, 0, 0,          4'b0000, 2, 0, 0, 32'hD, 32'hC, 32'hF, 32'hB);
    add(1, 1, 0, 2, 0, 0,          4'b0000, 3, 0, 0, 32'hD, 32'hC, 32'hF, 32'hB);
    add(1, 1, 0, 3, 0, 0,          4'b0000, 4, 0, 0, 32'hD, 32'hC, 32'hF, 32'hB);
    add(1, 1, 0, 1, 0, 0,          4'b0000, 4, 1, 0, 32'hD, 32'hC, 32'hF, 32'hB);
    add(1, 1, 0, 3, 1, 32'h11,     4'b0001, 4, 1, 0, 32'hD, 32'hC, 32'hF, 32'h11);
    add(1, 0, 0, 0, 1, 32'h22,     4'b0010, 3, 1, 0, 32'hD, 32'hC, 32'h22, 32'h11);
    add(1, 0, 0, 0, 1, 32'h33,     4'b0100, 2, 1, 0, 32'hD, 32'h33, 32'h22, 32'h11);
    add(1, 0, 0, 0, 1, 32'h44,     4'b1000, 1, 1, 0, 32'h44, 32'h33, 32'h22, 32'h11);
    add(1, 0, 0, 0, 1, 32'h55,     4'b1000, 0, 1, 0, 32'h55, 32'h33, 32'h22, 32'h11);
    // push+pop while empty: beat discarded, push kept
    add(1, 1, 0, 2, 1, 32'h66,     4'b0000, 1, 1, 1, 32'h55, 32'h33, 32'h22, 32'h11);
    add(1, 0, 0, 0, 1, 32'h77,     4'b0100, 0, 1, 1, 32'h55, 32'h77, 32'h22, 32'h11);
    // reset clears flags and data, then write-ack filter
    add(0, 0, 0, 0, 0, 0,          4'b0000, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0,          4'b0000, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 32'h88,     4'b0000, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,          4'b0000, 0, 0, 0, 0, 0, 0, 0);
    // reset with reads pending
    add(1, 1, 0, 0, 0, 0,          4'b0000, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0,          4'b0000, 2, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 2, 0, 0,          4'b0000, 3, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,          4'b0000, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 32'h99,     4'b0000, 0, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].av, tbl[i].ac, tbl[i].am, tbl[i].rv, tbl[i].rd);
      check_vec(i, tbl[i]);
    end

    // Streaming: one ack and one beat every cycle keeps one read in flight.
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 0);
    chk("stream_prime_pending", 0, NM*DW'(pending), NM*DW'(1));
    prev = 1;
    for (int i = 0; i < NM; i++) begin
      drive(1, 1, 0, MW'(i), 1, 32'h100 + i);
      chk("stream_data_read", i, NM*DW'(data_read), NM*DW'(1 << prev));
      chk("stream_rdata", i, NM*DW'(rdata[prev*DW +: DW]), NM*DW'(32'h100 + i));
      chk("stream_pending", i, NM*DW'(pending), NM*DW'(1));
      prev = i;
    end
    drive(1, 0, 0, 0, 1, 32'h200);
    chk("stream_drain_data_read", 0, NM*DW'(data_read), NM*DW'(4'b1000));
    chk("stream_drain_rdata", 0, NM*DW'(rdata[3*DW +: DW]), NM*DW'(32'h200));
    chk("stream_drain_pending", 0, NM*DW'(pending), NM*DW'(0));
    drive(1, 0, 0, 0, 0, 0);
    chk("stream_pulse_end", 0, NM*DW'(data_read), NM*DW'(0));
    chk("stream_no_err", 0, NM*DW'({err_ovf, err_unexp}), NM*DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
